// File: rtl/fifo_burst_reader_if.sv
// Handshake bundle for fifo_burst_reader: FWFT FIFO read side, output word
// stream and the completed-burst counter. The flush request exists only when
// FIFO_BURST_READER_FLUSH_EN is defined.
interface fifo_burst_reader_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 4
);

  // FWFT FIFO read side
  logic [DATA_WIDTH-1:0]  fifo_dout;
  logic                   fifo_empty;
  logic [DEPTH_WIDTH-1:0] fifo_cnt;
  logic                   fifo_rd_en;

  // Output word stream
  logic [DATA_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic                   m_sop;
  logic                   m_eop;

  // Status
  logic [15:0]            burst_cnt;

`ifdef FIFO_BURST_READER_FLUSH_EN
  logic                   flush;

  modport master (
    input  fifo_dout, fifo_empty, fifo_cnt, m_ready, flush,
    output fifo_rd_en, m_data, m_valid, m_sop, m_eop, burst_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_cnt, m_ready, flush,
    input  fifo_rd_en, m_data, m_valid, m_sop, m_eop, burst_cnt
  );
`else
  modport master (
    input  fifo_dout, fifo_empty, fifo_cnt, m_ready,
    output fifo_rd_en, m_data, m_valid, m_sop, m_eop, burst_cnt
  );

  modport slave (
    output fifo_dout, fifo_empty, fifo_cnt, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_sop, m_eop, burst_cnt
  );
`endif

endinterface

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: waits until an FWFT FIFO holds a full burst of
// BURST_LEN words, then streams exactly that many words through a single
// registered output stage, marking the first word with m_sop and the last
// with m_eop, and counting completed bursts in burst_cnt.
//
// Optional feature: define FIFO_BURST_READER_FLUSH_EN to add a flush input.
// A flush pulse arms a flag that drains words left below BURST_LEN as
// one-word bursts (m_sop = m_eop = 1) until the FIFO runs empty.
module fifo_burst_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 4,
  parameter int BURST_LEN   = 4
) (
  input logic                 clk,
  input logic                 rst,
  fifo_burst_reader_if.master bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [7:0] FULL_LEN = 8'(BURST_LEN);

  // Burst sequencing state
  state_t                state_q;
  state_t                state_d;
  logic [7:0]            beat_q;
  logic [7:0]            beat_d;
  logic [7:0]            len_q;
  logic [7:0]            len_d;

  // Output register stage
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_valid_q;
  logic                  m_sop_q;
  logic                  m_eop_q;
  logic [15:0]           burst_cnt_q;

  // Per-cycle decisions
  logic                  full_avail;
  logic                  last_beat;
  logic                  load;
  logic                  xfer;

`ifdef FIFO_BURST_READER_FLUSH_EN
  logic                  flush_pending_q;
  logic                  flush_pending_d;
`endif

  // The count is a lower bound on the words present, so a full burst can
  // always be popped without truncation once this holds.
  assign full_avail = 32'(bus.fifo_cnt) >= 32'(BURST_LEN);
  assign last_beat  = (beat_q == (len_q - 8'd1));

  // A word moves from the FIFO head into the output register whenever the
  // register is empty or being drained this cycle. Reset gates the pop so a
  // burst caught mid-way never takes another word.
  assign load = !rst && (state_q == BURST) && !bus.fifo_empty &&
                (!m_valid_q || bus.m_ready);
  assign xfer = m_valid_q && bus.m_ready;

  assign bus.fifo_rd_en = load;
  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_sop      = m_sop_q;
  assign bus.m_eop      = m_eop_q;
  assign bus.burst_cnt  = burst_cnt_q;

  // Next-state logic: start bursts from IDLE, advance the beat on each load.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    state_d = state_q;
    beat_d  = beat_q;
    len_d   = len_q;
`ifdef FIFO_BURST_READER_FLUSH_EN
    flush_pending_d = flush_pending_q | bus.flush;
`endif

    unique case (state_q)
      IDLE: begin
        if (full_avail) begin
          // A full burst wins over a pending flush.
          state_d = BURST;
          beat_d  = 8'd0;
          len_d   = FULL_LEN;
        end
`ifdef FIFO_BURST_READER_FLUSH_EN
        else if (flush_pending_q && !bus.fifo_empty) begin
          // Drain leftovers one word at a time.
          state_d = BURST;
          beat_d  = 8'd0;
          len_d   = 8'd1;
        end else if (bus.fifo_empty && !bus.flush) begin
          flush_pending_d = 1'b0;
        end
`endif
      end

      BURST: begin
        if (load) begin
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= 8'd0;
      len_q   <= FULL_LEN;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
    end
  end

`ifdef FIFO_BURST_READER_FLUSH_EN
  // Flush request flag: armed by a flush pulse, cleared once drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_pending_q <= 1'b0;
    end else begin
      flush_pending_q <= flush_pending_d;
    end
  end
`endif

  // Output register: capture the FIFO head on load, drop valid after a
  // transfer with nothing behind it, otherwise hold the word steady.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_sop_q   <= 1'b0;
      m_eop_q   <= 1'b0;
    end else if (load) begin
      m_data_q  <= bus.fifo_dout;
      m_valid_q <= 1'b1;
      m_sop_q   <= (beat_q == 8'd0);
      m_eop_q   <= last_beat;
    end else if (xfer) begin
      m_valid_q <= 1'b0;
    end
  end

  // Completed-burst counter: one count per accepted end-of-burst word.
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= 16'd0;
    end else if (xfer && m_eop_q) begin
      burst_cnt_q <= burst_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed testbench for fifo_burst_reader with BURST_LEN=4. A queue models
// the FWFT FIFO; every cycle is advanced by tick(), which records pops and
// accepted output words. Inputs change and outputs are inspected on the
// falling edge.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int CW = 4;
  localparam int BL = 4;

  logic clk;
  logic rst;

  fifo_burst_reader_if #(.DATA_WIDTH(DW), .DEPTH_WIDTH(CW)) bus ();

  fifo_burst_reader #(
    .DATA_WIDTH (DW),
    .DEPTH_WIDTH(CW),
    .BURST_LEN  (BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] rx_data[$];
  logic          rx_sop[$];
  logic          rx_eop[$];
  int            rx_cyc[$];
  int            cyc       = 0;
  int            pop_count = 0;
  int            rd_total  = 0;
  int            bad_pop   = 0;

  task automatic drive_fifo();
    bus.fifo_empty = (fq.size() == 0);
    bus.fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
    bus.fifo_cnt   = (fq.size() > 15) ? 4'd15 : 4'(fq.size());
  endtask

  task automatic push(input logic [DW-1:0] w);
    fq.push_back(w);
    drive_fifo();
  endtask

  // One clock: sample pop/transfer before the edge, pop after it, then
  // return on the falling edge.
  task automatic tick();
    logic rd;
    #1;
    rd = bus.fifo_rd_en;
    if (rd) begin
      rd_total++;
      pop_count++;
      if (fq.size() == 0) bad_pop++;
    end
    if (bus.m_valid && bus.m_ready) begin
      rx_data.push_back(bus.m_data);
      rx_sop.push_back(bus.m_sop);
      rx_eop.push_back(bus.m_eop);
      rx_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    if (rd && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rx_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    ok = (rx_data.size() >= n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.m_ready = 1'b0;
`ifdef FIFO_BURST_READER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    fq.delete();
    drive_fifo();
    tick();
    tick();
    rst = 1'b0;
    rx_data.delete();
    rx_sop.delete();
    rx_eop.delete();
    rx_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m_ready = 1'b1;
`ifdef FIFO_BURST_READER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    drive_fifo();
    tick();
    tick();
    checks++;
    if (bus.m_valid !== 1'b0) begin
      failures++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid);
    end
    checks++;
    if (bus.m_sop !== 1'b0 || bus.m_eop !== 1'b0) begin
      failures++; $display("FAIL reset_sop_eop: got %b%b want 00", bus.m_sop, bus.m_eop);
    end
    checks++;
    if (bus.m_data !== '0) begin
      failures++; $display("FAIL reset_m_data: got %h want 0", bus.m_data);
    end
    checks++;
    if (bus.burst_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_burst_cnt: got %0d want 0", bus.burst_cnt);
    end
    checks++;
    if (dut.state_q !== 1'b0) begin
      failures++; $display("FAIL reset_state: got %b want IDLE(0)", dut.state_q);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.m_valid !== 1'b0 || rd_total !== 0) begin
      failures++; $display("FAIL reset_idle_after: got valid=%b pops=%0d want 0/0", bus.m_valid, rd_total);
    end
  endtask

  task automatic test_single_burst();
    bit ok;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i));
    run_until(4, 30, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL single_timeout: got %0d words want 4", rx_data.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rx_data[i] !== 32'hA000_0000 + 32'(i) || rx_sop[i] !== (i == 0) || rx_eop[i] !== (i == 3)) begin
        failures++;
        $display("FAIL single_word%0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                 i, rx_data[i], rx_sop[i], rx_eop[i], 32'hA000_0000 + 32'(i), i == 0, i == 3);
      end
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (rx_cyc[i] - rx_cyc[i-1] !== 1) begin
        failures++; $display("FAIL single_gap%0d: got %0d cycles want 1", i, rx_cyc[i] - rx_cyc[i-1]);
      end
    end
    checks++;
    if (bus.burst_cnt !== 16'd1) begin
      failures++; $display("FAIL single_burst_cnt: got %0d want 1", bus.burst_cnt);
    end
    tick();
    checks++;
    if (bus.m_valid !== 1'b0 || fq.size() !== 0) begin
      failures++; $display("FAIL single_drained: got valid=%b left=%0d want 0/0", bus.m_valid, fq.size());
    end
  endtask

`ifndef FIFO_BURST_READER_FLUSH_EN
  task automatic test_no_partial();
    int rd_start;
    int valid_seen;
    do_reset();
    bus.m_ready = 1'b1;
    rd_start   = rd_total;
    valid_seen = 0;
    for (int i = 0; i < 3; i++) push(32'hB000_0000 + 32'(i));
    for (int i = 0; i < 12; i++) begin
      if (bus.m_valid) valid_seen++;
      tick();
    end
    checks++;
    if (rd_total - rd_start !== 0) begin
      failures++; $display("FAIL partial_rd_en: got %0d pops want 0", rd_total - rd_start);
    end
    checks++;
    if (valid_seen !== 0 || rx_data.size() !== 0) begin
      failures++; $display("FAIL partial_valid: got %0d valid cycles want 0", valid_seen);
    end
    checks++;
    if (fq.size() !== 3) begin
      failures++; $display("FAIL partial_left: got %0d words want 3", fq.size());
    end
  endtask
`else
  task automatic test_flush();
    bit ok;
    do_reset();
    bus.m_ready = 1'b1;
    push(32'hC000_0000);
    push(32'hC000_0001);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (rx_data.size() !== 0) begin
      failures++; $display("FAIL flush_early: got %0d words want 0", rx_data.size());
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    run_until(2, 20, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL flush_timeout: got %0d words want 2", rx_data.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (rx_data[i] !== 32'hC000_0000 + 32'(i) || rx_sop[i] !== 1'b1 || rx_eop[i] !== 1'b1) begin
        failures++;
        $display("FAIL flush_word%0d: got %h sop=%b eop=%b want %h sop=1 eop=1",
                 i, rx_data[i], rx_sop[i], rx_eop[i], 32'hC000_0000 + 32'(i));
      end
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.burst_cnt !== 16'd2) begin
      failures++; $display("FAIL flush_burst_cnt: got %0d want 2", bus.burst_cnt);
    end
    checks++;
    if (dut.flush_pending_q !== 1'b0) begin
      failures++; $display("FAIL flush_pending: got %b want 0", dut.flush_pending_q);
    end
  endtask
`endif

  task automatic test_stall();
    int          t;
    int          unstable;
    logic        held;
    logic [DW-1:0] hd;
    logic        hs;
    logic        he;
    do_reset();
    for (int i = 0; i < 8; i++) push(32'hD000_0000 + 32'(i));
    t = 0;
    unstable = 0;
    while (rx_data.size() < 8 && t < 80) begin
      bus.m_ready = (t % 2 == 0);
      held = bus.m_valid && !bus.m_ready;
      hd = bus.m_data;
      hs = bus.m_sop;
      he = bus.m_eop;
      tick();
      if (held && (bus.m_valid !== 1'b1 || bus.m_data !== hd || bus.m_sop !== hs || bus.m_eop !== he))
        unstable++;
      t++;
    end
    checks++;
    if (rx_data.size() !== 8) begin
      failures++; $display("FAIL stall_timeout: got %0d words want 8", rx_data.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rx_data[i] !== 32'hD000_0000 + 32'(i) || rx_sop[i] !== (i % 4 == 0) || rx_eop[i] !== (i % 4 == 3)) begin
        failures++;
        $display("FAIL stall_word%0d: got %h sop=%b eop=%b want %h sop=%b eop=%b",
                 i, rx_data[i], rx_sop[i], rx_eop[i], 32'hD000_0000 + 32'(i), i % 4 == 0, i % 4 == 3);
      end
    end
    checks++;
    if (unstable !== 0) begin
      failures++; $display("FAIL stall_stable: got %0d changes while stalled want 0", unstable);
    end
    checks++;
    if (bus.burst_cnt !== 16'd2) begin
      failures++; $display("FAIL stall_burst_cnt: got %0d want 2", bus.burst_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int pops_before;
    int eops;
    int valid_seen;
    do_reset();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'hE000_0000 + 32'(i));
    run_until(6, 40, ok);
    checks++;
    if (!ok || bus.burst_cnt !== 16'd1) begin
      failures++; $display("FAIL midrst_setup: got words=%0d cnt=%0d want 6/1", rx_data.size(), bus.burst_cnt);
    end
    pops_before = pop_count;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.fifo_rd_en !== 1'b0) begin
      failures++; $display("FAIL midrst_rd_en: got %b want 0", bus.fifo_rd_en);
    end
    tick();
    checks++;
    if (bus.m_valid !== 1'b0 || bus.burst_cnt !== 16'd0) begin
      failures++; $display("FAIL midrst_outputs: got valid=%b cnt=%0d want 0/0", bus.m_valid, bus.burst_cnt);
    end
    checks++;
    if (dut.state_q !== 1'b0) begin
      failures++; $display("FAIL midrst_state: got %b want IDLE(0)", dut.state_q);
    end
    checks++;
    if (pop_count !== pops_before) begin
      failures++; $display("FAIL midrst_pop: got %0d pops want 0", pop_count - pops_before);
    end
    rst = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.m_valid) valid_seen++;
      tick();
    end
    eops = 0;
    foreach (rx_eop[i]) if (rx_eop[i] === 1'b1) eops++;
    checks++;
    if (valid_seen !== 0 || eops !== 1) begin
      failures++; $display("FAIL midrst_abandon: got valid=%0d eops=%0d want 0/1", valid_seen, eops);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    force dut.burst_cnt_q = 16'hFFFF;
    tick();
    release dut.burst_cnt_q;
    checks++;
    if (bus.burst_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL wrap_preload: got %h want ffff", bus.burst_cnt);
    end
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'hF000_0000 + 32'(i));
    run_until(4, 30, ok);
    checks++;
    if (!ok || bus.burst_cnt !== 16'h0000) begin
      failures++; $display("FAIL wrap_burst_cnt: got %h words=%0d want 0000/4", bus.burst_cnt, rx_data.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.m_ready = 1'b0;
`ifdef FIFO_BURST_READER_FLUSH_EN
    bus.flush = 1'b0;
`endif
    drive_fifo();
    @(negedge clk);
    test_reset();
    test_single_burst();
`ifndef FIFO_BURST_READER_FLUSH_EN
    test_no_partial();
`else
    test_flush();
`endif
    test_stall();
    test_reset_mid_burst();
    test_wrap();
    checks++;
    if (bad_pop !== 0) begin
      failures++; $display("FAIL pop_when_empty: got %0d want 0", bad_pop);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the width of one FIFO word.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 4, the width of fifo_cnt.
REQ-003 SHALL have parameter BURST_LEN, default 4, the words per full burst, legal range 2..255.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port fifo_dout, input, DATA_WIDTH bits: FWFT head word, valid while fifo_empty=0.
REQ-007 SHALL have port fifo_empty, input, 1 bit: FWFT FIFO has no head word.
REQ-008 SHALL have port fifo_cnt, input, DEPTH_WIDTH bits: FWFT FIFO backing-store occupancy, a lower bound on the words available.
REQ-009 SHALL have port fifo_rd_en, output, 1 bit: pops the head word in this cycle.
REQ-010 SHALL have port m_data, output, DATA_WIDTH bits: output word.
REQ-011 SHALL have port m_valid, output, 1 bit: m_data, m_sop and m_eop are valid.
REQ-012 SHALL have port m_ready, input, 1 bit: downstream accepts the word; a transfer occurs when m_valid=1 and m_ready=1.
REQ-013 SHALL have port m_sop, output, 1 bit: first word of a burst.
REQ-014 SHALL have port m_eop, output, 1 bit: last word of a burst.
REQ-015 SHALL have port burst_cnt, output, 16 bits: count of completed bursts, wrapping.
REQ-016 SHALL have port flush, input, 1 bit, present only under FIFO_BURST_READER_FLUSH_EN: one-cycle request to drain partial data.

Function
REQ-017 SHALL be a registered output stage: m_data, m_valid, m_sop and m_eop SHALL be flops with no combinational path from fifo_dout.
REQ-018 SHALL define the load condition load = (state=BURST) && !fifo_empty && (!m_valid || m_ready).
REQ-019 SHALL drive fifo_rd_en = load; this is the only combinational path, and it runs from m_ready and fifo_empty.
REQ-020 SHALL, on load, set m_data=fifo_dout and m_valid=1 at the next edge, giving a pop-to-m_valid latency of 1 cycle.
REQ-021 SHALL clear m_valid on a transfer when load=0.
REQ-022 SHALL hold m_data, m_sop and m_eop stable while m_valid=1 and m_ready=0.
REQ-023 SHALL implement state machine IDLE, BURST, with an 8-bit beat counter beat.
REQ-024 SHALL transition IDLE->BURST when fifo_cnt >= BURST_LEN, setting beat=0 and len=BURST_LEN.
REQ-025 SHALL remain in IDLE while fifo_cnt < BURST_LEN and SHALL never assert fifo_rd_en in IDLE.
REQ-026 SHALL, on each load in BURST, set m_sop=(beat==0), set m_eop=(beat==len-1), and increment beat.
REQ-027 SHALL, on the load with beat==len-1, return to IDLE at the next edge.
REQ-028 SHALL stall without a pop if fifo_empty=1 mid-burst, and SHALL resume when data arrives; a burst is never truncated.
REQ-029 SHALL increment burst_cnt by 1 on each transfer with m_eop=1, wrapping from 0xFFFF to 0.
REQ-030 SHALL allow a new burst's IDLE->BURST transition while the prior m_eop word still waits for m_ready; its first load occurs when the output register frees.

Reset
REQ-031 SHALL, with rst=1 at an edge, set state=IDLE, beat=0, m_valid=0, m_sop=0, m_eop=0, m_data=0 and burst_cnt=0, with flush_pending=0 when FIFO_BURST_READER_FLUSH_EN is defined.
REQ-032 SHALL hold fifo_rd_en=0 while rst=1.
REQ-033 SHALL, on reset mid-burst, abandon the partial burst without emitting m_eop, with no further pops.

Configuration
REQ-034 SHALL compile in, when FIFO_BURST_READER_FLUSH_EN is defined, a flush port and a flush_pending flop that is set on flush=1.
REQ-035 SHALL, with flush_pending=1 in IDLE, fifo_cnt < BURST_LEN and fifo_empty=0, enter BURST with len=1, so each word is emitted with m_sop=m_eop=1.
REQ-036 SHALL clear flush_pending in IDLE when fifo_empty=1 and flush=0; a full burst takes priority over a flush burst.
REQ-037 SHALL, when FIFO_BURST_READER_FLUSH_EN is undefined, have no flush port, and words below BURST_LEN SHALL remain in the FIFO indefinitely.

Verification
REQ-038 SHALL cover: BURST_LEN=4, 4 words written, m_ready=1 -> 4 transfers on consecutive cycles, sop on word 0, eop on word 3, burst_cnt=1.
REQ-039 SHALL cover: 3 words, macro undefined -> fifo_rd_en never asserts, m_valid stays 0.
REQ-040 SHALL cover: 8 words, m_ready toggled 1,0,1,0 -> 8 in-order words, m_data stable during stalls, 2 eops, burst_cnt=2.
REQ-041 SHALL cover: macro defined, 2 words then flush pulse -> 2 transfers each with sop=eop=1, burst_cnt=2, flush_pending=0 afterwards.
REQ-042 SHALL cover: rst asserted after word 2 of a burst -> next cycle m_valid=0, burst_cnt=0, state=IDLE, no pop.
REQ-043 SHALL cover: burst_cnt preloaded to 0xFFFF and one burst completed -> burst_cnt=0.
